// File: rtl/apb_ram_slave_if.sv
// APB bus bundle for apb_ram_slave. The pstrb signal exists only when
// APB_PSTRB_EN is defined.
interface apb_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
`ifdef APB_PSTRB_EN
    output pstrb,
`endif
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
`ifdef APB_PSTRB_EN
    input  pstrb,
`endif
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_slave.sv
// APB word-addressed RAM slave with programmable wait states and error response
// for out-of-range words. Define APB_PSTRB_EN to enable byte-lane write strobes.
module apb_ram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic            pclk,
  input logic            presetn,
  apb_ram_slave_if.slave bus
);

  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
`ifdef APB_PSTRB_EN
  localparam int                  NB        = DATA_WIDTH / 8;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q;
  logic                    oor_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef APB_PSTRB_EN
  logic [NB-1:0]           strb_q;
`endif
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    accept;
  logic                    wr_en;
  logic                    addr_oor;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign accept   = (state_q == ST_IDLE) && bus.psel && !bus.penable;
  assign addr_oor = ({1'b0, bus.paddr} >= DEPTH_W);
  assign rd_word  = mem[idx_q];
  assign wr_en    = (state_q == ST_READY) && bus.psel && bus.penable && wr_q && !oor_q;

  // NOTE: state and counter use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: both outputs get defaults before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (bus.penable) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Completion-cycle outputs; reads show live memory, otherwise prdata holds.
  always_comb begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    prdata_d    = prdata_q;
    if (state_q == ST_READY) begin
      bus.pready  = 1'b1;
      bus.pslverr = oor_q;
      if (!wr_q) prdata_d = oor_q ? '0 : rd_word;
    end
    bus.prdata = prdata_d;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) prdata_q <= '0;
    else          prdata_q <= prdata_d;
  end

  // Transfer attributes are latched in the setup cycle and held to completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef APB_PSTRB_EN
      strb_q  <= '0;
`endif
    end else if (accept) begin
      idx_q   <= bus.paddr[IDX_W-1:0];
      oor_q   <= addr_oor;
      wr_q    <= bus.pwrite;
      wdata_q <= bus.pwdata;
`ifdef APB_PSTRB_EN
      strb_q  <= bus.pstrb;
`endif
    end
  end

  // NOTE: the storage array has no reset branch; contents survive presetn and
  // an unwritten word reads as whatever the RAM powers up with.
  always_ff @(posedge pclk) begin
    if (wr_en) begin
`ifdef APB_PSTRB_EN
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
`else
      mem[idx_q] <= wdata_q;
`endif
    end
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// Directed bench for apb_ram_slave: one zero-wait and one two-wait instance
// share clock, reset and master signals; tgt selects which one psel reaches.
module tb_apb_ram_slave;

  logic        pclk;
  logic        presetn;
  logic        tgt;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          total;
  int          bad;

  apb_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus0 ();
  apb_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();

  apb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .bus(bus0.slave));
  apb_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(2)) u_dut2 (
    .pclk(pclk), .presetn(presetn), .bus(bus2.slave));

  assign bus0.psel    = psel && !tgt;
  assign bus2.psel    = psel && tgt;
  assign bus0.penable = penable;
  assign bus2.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus2.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus2.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus2.pwdata  = pwdata;
`ifdef APB_PSTRB_EN
  assign bus0.pstrb   = pstrb;
  assign bus2.pstrb   = pstrb;
`endif

  logic [31:0] cur_prdata;
  logic        cur_pready, cur_pslverr;
  assign cur_prdata  = tgt ? bus2.prdata  : bus0.prdata;
  assign cur_pready  = tgt ? bus2.pready  : bus0.pready;
  assign cur_pslverr = tgt ? bus2.pslverr : bus0.pslverr;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after completion
  // with psel low, so an immediate next call forms a back-to-back transfer.
  task automatic xfer(input logic t, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err, output int waits);
    bit done;
    done = 1'b0;
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; rd = 'x; err = 1'bx;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge pclk);
      if (cur_pready === 1'b1) begin
        rd = cur_prdata; err = cur_pslverr; done = 1'b1;
      end else begin
        waits++;
        total++;
        if (cur_pslverr !== 1'b0) begin
          bad++; $display("FAIL pslverr_without_pready: got %b want 0", cur_pslverr);
        end
      end
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL pready_timeout: got no pready want pready within 20 cycles");
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus0.pready !== 1'b0)   begin bad++; $display("FAIL rst_pready0: got %b want 0", bus0.pready); end
    total++; if (bus0.pslverr !== 1'b0)  begin bad++; $display("FAIL rst_pslverr0: got %b want 0", bus0.pslverr); end
    total++; if (bus0.prdata !== 32'h0)  begin bad++; $display("FAIL rst_prdata0: got %h want 0", bus0.prdata); end
    total++; if (bus2.pready !== 1'b0)   begin bad++; $display("FAIL rst_pready2: got %b want 0", bus2.pready); end
    total++; if (bus2.pslverr !== 1'b0)  begin bad++; $display("FAIL rst_pslverr2: got %b want 0", bus2.pslverr); end
    total++; if (bus2.prdata !== 32'h0)  begin bad++; $display("FAIL rst_prdata2: got %h want 0", bus2.prdata); end
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(2);
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF, rd, err, w);
    total++; if (w !== 0)      begin bad++; $display("FAIL zw_write_waits: got %0d want 0", w); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL zw_write_err: got %b want 0", err); end
    idle(1);
    xfer(1'b0, 1'b0, 8'h03, 32'h0, 4'h0, rd, err, w);
    total++; if (w !== 0)              begin bad++; $display("FAIL zw_read_waits: got %0d want 0", w); end
    total++; if (err !== 1'b0)         begin bad++; $display("FAIL zw_read_err: got %b want 0", err); end
    total++; if (rd !== 32'hDEADBEEF)  begin bad++; $display("FAIL zw_read_data: got %h want deadbeef", rd); end
    idle(1);
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int w;
    xfer(1'b1, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF, rd, err, w);
    total++; if (w !== 2) begin bad++; $display("FAIL ws_write_waits: got %0d want 2", w); end
    idle(1);
    xfer(1'b1, 1'b0, 8'h03, 32'h0, 4'h0, rd, err, w);
    total++; if (w !== 2)             begin bad++; $display("FAIL ws_read_waits: got %0d want 2", w); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL ws_read_err: got %b want 0", err); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_read_data: got %h want deadbeef", rd); end
    // The cycle after completion must show pready low while prdata holds.
    @(negedge pclk);
    total++; if (cur_pready !== 1'b0)         begin bad++; $display("FAIL ws_pready_after: got %b want 0", cur_pready); end
    total++; if (cur_prdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_prdata_hold: got %h want deadbeef", cur_prdata); end
    @(posedge pclk); #1;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 1'b1, 8'h00, 32'hCAFEF00D, 4'hF, rd, err, w);
    xfer(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL oor_pre_data: got %h want cafef00d", rd); end
    xfer(1'b0, 1'b1, 8'h10, 32'h12345678, 4'hF, rd, err, w);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_write_err: got %b want 1", err); end
    total++; if (w !== 0)      begin bad++; $display("FAIL oor_write_waits: got %0d want 0", w); end
    xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, w);
    total++; if (err !== 1'b1)  begin bad++; $display("FAIL oor_read_err: got %b want 1", err); end
    total++; if (rd !== 32'h0)  begin bad++; $display("FAIL oor_read_data: got %h want 0", rd); end
    xfer(1'b0, 1'b0, 8'hFF, 32'h0, 4'h0, rd, err, w);
    total++; if (err !== 1'b1)  begin bad++; $display("FAIL oor_top_err: got %b want 1", err); end
    xfer(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL oor_alias_data: got %h want cafef00d", rd); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL oor_alias_err: got %b want 0", err); end
    xfer(1'b0, 1'b0, 8'h0F, 32'h0, 4'h0, rd, err, w);
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL last_word_err: got %b want 0", err); end
    idle(1);
  endtask

  task automatic test_pstrb();
    logic [31:0] rd; logic err; int w;
    xfer(1'b0, 1'b1, 8'h05, 32'h00000000, 4'hF, rd, err, w);
    xfer(1'b0, 1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, rd, err, w);
    xfer(1'b0, 1'b0, 8'h05, 32'h0, 4'h0, rd, err, w);
`ifdef APB_PSTRB_EN
    total++; if (rd !== 32'h00BB00DD) begin bad++; $display("FAIL strb_lanes: got %h want 00bb00dd", rd); end
    xfer(1'b0, 1'b1, 8'h05, 32'h11223344, 4'b0000, rd, err, w);
    total++; if (err !== 1'b0 || w !== 0) begin bad++; $display("FAIL strb_zero_done: got err=%b waits=%0d want err=0 waits=0", err, w); end
    xfer(1'b0, 1'b0, 8'h05, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'h00BB00DD) begin bad++; $display("FAIL strb_zero_nochange: got %h want 00bb00dd", rd); end
`else
    total++; if (rd !== 32'hAABBCCDD) begin bad++; $display("FAIL full_word_write: got %h want aabbccdd", rd); end
`endif
    idle(1);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic err; int w;
    xfer(1'b1, 1'b1, 8'h07, 32'h00000011, 4'hF, rd, err, w);
    xfer(1'b1, 1'b0, 8'h07, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'h11) begin bad++; $display("FAIL rmw_pre_data: got %h want 11", rd); end
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    total++; if (cur_pready !== 1'b0)  begin bad++; $display("FAIL rmw_pready: got %b want 0", cur_pready); end
    total++; if (cur_prdata !== 32'h0) begin bad++; $display("FAIL rmw_prdata: got %h want 0", cur_prdata); end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);
    xfer(1'b1, 1'b0, 8'h07, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'h11) begin bad++; $display("FAIL rmw_retained: got %h want 11", rd); end
    total++; if (w !== 2)       begin bad++; $display("FAIL rmw_post_waits: got %0d want 2", w); end
    idle(1);
  endtask

  task automatic test_psel_drop();
    logic [31:0] rd; logic err; int w;
    xfer(1'b1, 1'b1, 8'h09, 32'h00000909, 4'hF, rd, err, w);
    // Drop psel in the completion cycle: no write may land.
    tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h09; pwdata = 32'h9999; pstrb = 4'hF;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    total++; if (cur_pready !== 1'b0) begin bad++; $display("FAIL drop_ready_pready: got %b want 0", cur_pready); end
    @(posedge pclk); #1;
    // Drop psel while wait states are still counting.
    psel = 1'b1; penable = 1'b0; pwdata = 32'h7777;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    @(posedge pclk); #1;
    @(negedge pclk);
    total++; if (cur_pready !== 1'b0) begin bad++; $display("FAIL drop_wait_pready: got %b want 0", cur_pready); end
    @(posedge pclk); #1;
    xfer(1'b1, 1'b0, 8'h09, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'h00000909) begin bad++; $display("FAIL drop_no_write: got %h want 00000909", rd); end
    total++; if (w !== 2)             begin bad++; $display("FAIL drop_recover_waits: got %0d want 2", w); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err, err1; int w, w1;
    xfer(1'b0, 1'b1, 8'h01, 32'hA5A55A5A, 4'hF, rd, err1, w1);
    xfer(1'b0, 1'b0, 8'h01, 32'h0, 4'h0, rd, err, w);
    total++; if (err1 !== 1'b0 || w1 !== 0) begin bad++; $display("FAIL b2b0_write: got err=%b waits=%0d want err=0 waits=0", err1, w1); end
    total++; if (rd !== 32'hA5A55A5A)       begin bad++; $display("FAIL b2b0_read: got %h want a5a55a5a", rd); end
    total++; if (w !== 0)                   begin bad++; $display("FAIL b2b0_waits: got %0d want 0", w); end
    xfer(1'b1, 1'b1, 8'h01, 32'h3C3CC3C3, 4'hF, rd, err1, w1);
    xfer(1'b1, 1'b0, 8'h01, 32'h0, 4'h0, rd, err, w);
    total++; if (rd !== 32'h3C3CC3C3)       begin bad++; $display("FAIL b2b2_read: got %h want 3c3cc3c3", rd); end
    total++; if (w1 !== 2 || w !== 2)       begin bad++; $display("FAIL b2b2_waits: got %0d/%0d want 2/2", w1, w); end
    idle(1);
  endtask

  initial begin
    total = 0; bad = 0;
    presetn = 1'b0; tgt = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_out_of_range();
    test_pstrb();
    test_reset_mid_wait();
    test_psel_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
